// File: rtl/memory_access_unit_pkg.sv
// Shared opcode, funct3, error-code and state encodings for the memory stage.
package memory_access_unit_pkg;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;

   localparam logic [2:0] FUNC_LB  = 3'b000;
   localparam logic [2:0] FUNC_LH  = 3'b001;
   localparam logic [2:0] FUNC_LW  = 3'b010;
   localparam logic [2:0] FUNC_LBU = 3'b100;
   localparam logic [2:0] FUNC_LHU = 3'b101;
   localparam logic [2:0] FUNC_SB  = 3'b000;
   localparam logic [2:0] FUNC_SH  = 3'b001;
   localparam logic [2:0] FUNC_SW  = 3'b010;

   localparam logic [1:0] ERR_NONE     = 2'b00;
   localparam logic [1:0] ERR_MISALIGN = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
   localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

   localparam logic [1:0] MEM_IDLE   = 2'd0;
   localparam logic [1:0] MEM_ACCESS = 2'd1;
   localparam logic [1:0] MEM_DONE   = 2'd2;

endpackage

// File: rtl/memory_access_unit_load_store_align.sv
// Byte-lane steering: store byte enables/replicated data, load lane extraction
// with sign/zero extension, and misalign/illegal-width detection.
module load_store_align
   import memory_access_unit_pkg::*;
(
   input  logic        is_store,
   input  logic [2:0]  funct3,
   input  logic [1:0]  off,
   input  logic [31:0] val2,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata,
   output logic [31:0] ld_val,
   output logic        misalign,
   output logic        illegal
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      be       = 4'b0000;
      wdata    = '0;
      ld_val   = '0;
      misalign = 1'b0;
      byte_sel = rdata[{off, 3'b000} +: 8];
      half_sel = off[1] ? rdata[31:16] : rdata[15:0];

      case (funct3[1:0])
         2'b00: be = 4'b0001 << off;
         2'b01: begin
            be       = off[1] ? 4'b1100 : 4'b0011;
            misalign = off[0];
         end
         2'b10: begin
            be       = 4'b1111;
            misalign = (off != 2'b00);
         end
         default: be = 4'b0000;
      endcase

      // Stores only have three legal widths; loads additionally allow the unsigned byte/half forms.
      illegal = is_store ? (funct3 >= 3'b011)
                         : (funct3 == 3'b011 || funct3[2:1] == 2'b11);

      if (is_store) begin
         case (funct3)
            FUNC_SB: wdata = {4{val2[7:0]}};
            FUNC_SH: wdata = {2{val2[15:0]}};
            FUNC_SW: wdata = val2;
            default: wdata = '0;
         endcase
      end else begin
         case (funct3)
            FUNC_LB:  ld_val = {{24{byte_sel[7]}}, byte_sel};
            FUNC_LH:  ld_val = {{16{half_sel[15]}}, half_sel};
            FUNC_LW:  ld_val = rdata;
            FUNC_LBU: ld_val = {24'd0, byte_sel};
            FUNC_LHU: ld_val = {16'd0, half_sel};
            default:  ld_val = '0;
         endcase
      end
   end

endmodule

// File: rtl/memory_access_unit.sv
// Memory stage: runs loads/stores as req/ack bus transactions and returns the
// aligned load value to writeback, stalling upstream while busy.
//
// state      | meaning
// MEM_IDLE   | waiting for start_i; decodes op, errors, bus request setup
// MEM_ACCESS | mem_req_o held; waiting for mem_ack_i or timeout
// MEM_DONE   | done_o pulse; valM_o/err_o valid
module memory_access_unit
   import memory_access_unit_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int ADDR_W         = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic [6:0]        opcode_i,
   input  logic [2:0]        funct3_i,
   input  logic [ADDR_W-1:0] valE_i,
   input  logic [ADDR_W-1:0] val2_i,
   output logic [ADDR_W-1:0] valM_o,
   output logic              done_o,
   output logic [1:0]        err_o,
   output logic              busy_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [3:0]        mem_be_o,
   output logic [ADDR_W-1:0] mem_wdata_o,
   input  logic [ADDR_W-1:0] mem_rdata_i,
   input  logic              mem_ack_i
);

   localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [1:0]        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] valm_q, valm_d;
   logic [1:0]        err_q, err_d;
   logic              req_q, req_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [3:0]        be_q, be_d;
   logic [ADDR_W-1:0] wdata_q, wdata_d;
   logic [2:0]        f3_q, f3_d;
   logic [1:0]        off_q, off_d;

   logic              in_idle, is_load, is_store, al_store;
   logic [2:0]        al_f3;
   logic [1:0]        al_off;
   logic [3:0]        al_be;
   logic [ADDR_W-1:0] al_wdata, al_ld;
   logic              al_misalign, al_illegal;

   assign in_idle  = (state_q == MEM_IDLE);
   assign is_load  = (opcode_i == OP_LOAD);
   assign is_store = (opcode_i == OP_STORE);

   // Live operands set up the request; the latched copy steers the response lane.
   assign al_store = in_idle ? is_store        : we_q;
   assign al_f3    = in_idle ? funct3_i        : f3_q;
   assign al_off   = in_idle ? valE_i[1:0]     : off_q;

   load_store_align u_align (
      .is_store (al_store),
      .funct3   (al_f3),
      .off      (al_off),
      .val2     (val2_i),
      .rdata    (mem_rdata_i),
      .be       (al_be),
      .wdata    (al_wdata),
      .ld_val   (al_ld),
      .misalign (al_misalign),
      .illegal  (al_illegal)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      valm_d  = valm_q;
      err_d   = err_q;
      req_d   = req_q;
      we_d    = we_q;
      addr_d  = addr_q;
      be_d    = be_q;
      wdata_d = wdata_q;
      f3_d    = f3_q;
      off_d   = off_q;

      case (state_q)
         MEM_IDLE: begin
            if (start_i) begin
               state_d = MEM_DONE;
               valm_d  = '0;
               if (!is_load && !is_store) begin
                  err_d = ERR_NONE;
               end else if (al_illegal) begin
                  err_d = ERR_ILLEGAL;
               end else if (al_misalign) begin
                  err_d = ERR_MISALIGN;
               end else begin
                  state_d = MEM_ACCESS;
                  cnt_d   = '0;
                  req_d   = 1'b1;
                  we_d    = is_store;
                  addr_d  = {valE_i[ADDR_W-1:2], 2'b00};
                  be_d    = al_be;
                  wdata_d = al_wdata;
                  f3_d    = funct3_i;
                  off_d   = valE_i[1:0];
               end
            end
         end
         MEM_ACCESS: begin
            if (mem_ack_i) begin
               state_d = MEM_DONE;
               req_d   = 1'b0;
               cnt_d   = '0;
               err_d   = ERR_NONE;
               valm_d  = we_q ? '0 : al_ld;
            end else if (TIMEOUT_CYCLES != 0 && cnt_q == CNT_LAST) begin
               state_d = MEM_DONE;
               req_d   = 1'b0;
               cnt_d   = '0;
               err_d   = ERR_TIMEOUT;
               valm_d  = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         MEM_DONE: state_d = MEM_IDLE;
         default:  state_d = MEM_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= MEM_IDLE;
         cnt_q   <= '0;
         valm_q  <= '0;
         err_q   <= ERR_NONE;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         be_q    <= '0;
         wdata_q <= '0;
         f3_q    <= '0;
         off_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         valm_q  <= valm_d;
         err_q   <= err_d;
         req_q   <= req_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         be_q    <= be_d;
         wdata_q <= wdata_d;
         f3_q    <= f3_d;
         off_q   <= off_d;
      end
   end

   assign valM_o      = valm_q;
   assign err_o       = err_q;
   assign done_o      = (state_q == MEM_DONE);
   assign busy_o      = !in_idle;
   assign mem_req_o   = req_q;
   assign mem_we_o    = we_q;
   assign mem_addr_o  = addr_q;
   assign mem_be_o    = be_q;
   assign mem_wdata_o = wdata_q;

endmodule

// File: tb/tb_memory_access_unit.sv
// Scoreboard bench for memory_access_unit: directed cases plus random ops
// against an arithmetic reference model, with independent bus and result monitors.
module tb_memory_access_unit;

   localparam int TO = 4;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        start_i = 1'b0;
   logic [6:0]  opcode_i = '0;
   logic [2:0]  funct3_i = '0;
   logic [31:0] valE_i = '0;
   logic [31:0] val2_i = '0;
   logic [31:0] valM_o;
   logic        done_o;
   logic [1:0]  err_o;
   logic        busy_o;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [31:0] mem_addr_o;
   logic [3:0]  mem_be_o;
   logic [31:0] mem_wdata_o;
   logic [31:0] mem_rdata_i = '0;
   logic        mem_ack_i = 1'b0;

   memory_access_unit #(.TIMEOUT_CYCLES(TO), .ADDR_W(32)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .opcode_i(opcode_i),
      .funct3_i(funct3_i), .valE_i(valE_i), .val2_i(val2_i), .valM_o(valM_o),
      .done_o(done_o), .err_o(err_o), .busy_o(busy_o), .mem_req_o(mem_req_o),
      .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o),
      .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [31:0] valm;
      logic [1:0]  err;
      bit          chk_valm;
   } res_t;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
      int          cycles;
   } bus_t;

   res_t exp_q[$];
   bus_t bus_q[$];

   int n_vec = 0;
   int n_err = 0;

   int          ack_lat = 0;
   logic [31:0] rdata_drv = '0;
   logic        force_ack = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      n_vec++;
      n_err++;
      $display("FAIL %s: got event-missing expected event-seen", name);
   endtask

   // Reference model: expected result and bus request from the architectural rules.
   function automatic void model(input logic [6:0] op, input logic [2:0] f3,
                                 input logic [31:0] vale, input logic [31:0] val2,
                                 input logic [31:0] rdata, input int lat,
                                 output bit has_bus, output res_t r, output bus_t b);
      int          off, size;
      bit          ld, st;
      logic [31:0] lane;
      off  = int'(vale % 4);
      size = int'(f3 % 4);
      ld   = (op == 7'h03);
      st   = (op == 7'h23);
      has_bus    = 0;
      r.valm     = 0;
      r.err      = 2'd0;
      r.chk_valm = 1;
      b.addr = 0; b.we = 0; b.be = 0; b.wdata = 0; b.cycles = -1;
      if (!ld && !st) return;
      if ((ld && (f3 == 3 || f3 == 6 || f3 == 7)) || (st && f3 >= 3)) begin
         r.err      = 2'd3;
         r.chk_valm = 0;
         return;
      end
      if ((size == 1 && off % 2 == 1) || (size == 2 && off != 0)) begin
         r.err = 2'd1;
         return;
      end
      has_bus = 1;
      b.addr  = vale - off;
      b.we    = st;
      b.be    = (size == 0) ? 4'(1 << off) : (size == 1) ? (off >= 2 ? 4'hC : 4'h3) : 4'hF;
      if (st) b.wdata = (size == 0) ? val2 % 256 * 32'h01010101
                      : (size == 1) ? val2 % 65536 * 32'h00010001 : val2;
      b.cycles = (lat == 0) ? TO : lat;
      if (lat == 0) begin
         r.err = 2'd2;
         return;
      end
      if (ld) begin
         lane = rdata >> (8 * off);
         case (f3)
            3'd0: r.valm = (lane % 256 >= 128) ? lane % 256 + 32'hFFFFFF00 : lane % 256;
            3'd1: r.valm = (lane % 65536 >= 32768) ? lane % 65536 + 32'hFFFF0000 : lane % 65536;
            3'd2: r.valm = rdata;
            3'd4: r.valm = lane % 256;
            default: r.valm = lane % 65536;
         endcase
      end
   endfunction

   // Bus responder: ack on the lat-th cycle that the request is seen.
   int resp_cnt = 0;
   always @(negedge clk_i) begin
      if (mem_req_o && !mem_ack_i) begin
         resp_cnt++;
         mem_ack_i = (ack_lat != 0 && resp_cnt == ack_lat);
      end else begin
         resp_cnt  = 0;
         mem_ack_i = 1'b0;
      end
      if (force_ack) mem_ack_i = 1'b1;
      mem_rdata_i = mem_ack_i ? rdata_drv : ~rdata_drv;
   end

   // Result monitor.
   logic done_prev = 1'b0;
   always @(negedge clk_i) begin
      res_t e;
      if (done_prev) begin
         chk("post_done_busy", {31'd0, busy_o}, 32'd0);
         chk("post_done_pulse", {31'd0, done_o}, 32'd0);
      end
      if (done_o) begin
         if (exp_q.size() == 0) begin
            fail("unexpected_done");
         end else begin
            e = exp_q.pop_front();
            chk("err", {30'd0, err_o}, {30'd0, e.err});
            if (e.chk_valm) chk("valM", valM_o, e.valm);
         end
      end
      done_prev = done_o;
   end

   // Bus monitor.
   logic req_prev = 1'b0;
   bit   cur_ok = 0;
   int   hi_cnt = 0;
   bus_t cur;
   always @(negedge clk_i) begin
      if (mem_req_o) begin
         if (!req_prev) begin
            hi_cnt = 1;
            if (bus_q.size() == 0) begin
               cur_ok = 0;
               fail("unexpected_req");
            end else begin
               cur    = bus_q.pop_front();
               cur_ok = 1;
            end
         end else begin
            hi_cnt++;
         end
         if (cur_ok) begin
            chk("addr", mem_addr_o, cur.addr);
            chk("we", {31'd0, mem_we_o}, {31'd0, cur.we});
            chk("be", {28'd0, mem_be_o}, {28'd0, cur.be});
            chk("wdata", mem_wdata_o, cur.wdata);
         end
      end else if (req_prev && cur_ok && cur.cycles >= 0) begin
         chk("req_cycles", hi_cnt, cur.cycles);
      end
      req_prev = mem_req_o;
   end

   task automatic run_op(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] vale,
                         input logic [31:0] val2, input logic [31:0] rdata, input int lat,
                         input bit hold);
      bit   has_bus;
      res_t r;
      bus_t b;
      int   w;
      model(op, f3, vale, val2, rdata, lat, has_bus, r, b);
      exp_q.push_back(r);
      if (has_bus) bus_q.push_back(b);
      @(negedge clk_i);
      opcode_i  = op;
      funct3_i  = f3;
      valE_i    = vale;
      val2_i    = val2;
      rdata_drv = rdata;
      ack_lat   = lat;
      start_i   = 1'b1;
      @(negedge clk_i);
      if (!hold) start_i = 1'b0;
      if (!has_bus) begin
         chk("fast_done", {31'd0, done_o}, 32'd1);
      end else begin
         w = 0;
         while (!done_o && w < 20) begin
            @(negedge clk_i);
            w++;
         end
         if (!done_o) fail("done_wait");
      end
      if (hold) begin
         @(negedge clk_i);
         start_i = 1'b0;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus_t        b;
      int          r;
      logic [6:0]  op;
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      chk("rst_valM", valM_o, 32'd0);
      chk("rst_flags", {26'd0, done_o, err_o, busy_o, mem_req_o, mem_we_o}, 32'd0);
      chk("rst_bus", {mem_addr_o[27:0], mem_be_o}, 32'd0);
      chk("rst_wdata", mem_wdata_o, 32'd0);
      rst_i = 1'b0;

      run_op(7'h23, 3'd2, 32'h100, 32'hDEADBEEF, 32'h0, 3, 0);
      run_op(7'h03, 3'd0, 32'h203, 32'h0, 32'h80FF0000, 2, 0);
      run_op(7'h03, 3'd4, 32'h203, 32'h0, 32'h80FF0000, 1, 0);
      run_op(7'h03, 3'd1, 32'h301, 32'h0, 32'h0, 1, 0);
      run_op(7'h03, 3'd2, 32'h302, 32'h0, 32'h0, 1, 0);
      run_op(7'h03, 3'd2, 32'h304, 32'h0, 32'h12345678, 0, 0);
      run_op(7'h03, 3'd5, 32'h306, 32'h0, 32'hBEEF1234, TO, 0);
      run_op(7'h03, 3'd6, 32'h300, 32'h0, 32'h0, 1, 0);
      run_op(7'h23, 3'd3, 32'h300, 32'h0, 32'h0, 1, 0);
      run_op(7'h33, 3'd0, 32'h300, 32'h0, 32'h0, 1, 0);
      run_op(7'h23, 3'd1, 32'h402, 32'h1234, 32'h0, 3, 1);
      run_op(7'h23, 3'd0, 32'h405, 32'hA5, 32'h0, 1, 0);

      // Reset in the middle of ACCESS, then a stray ack in IDLE.
      b.addr = 32'h500; b.we = 0; b.be = 4'hF; b.wdata = 0; b.cycles = -1;
      bus_q.push_back(b);
      @(negedge clk_i);
      opcode_i = 7'h03; funct3_i = 3'd2; valE_i = 32'h500; ack_lat = 0; start_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
      @(negedge clk_i);
      rst_i = 1'b1;
      @(negedge clk_i);
      chk("rst_mid_req", {31'd0, mem_req_o}, 32'd0);
      chk("rst_mid_busy", {31'd0, busy_o}, 32'd0);
      chk("rst_mid_valM", valM_o, 32'd0);
      rst_i = 1'b0;
      @(posedge clk_i);
      #1 force_ack = 1'b1;
      @(posedge clk_i);
      #1 force_ack = 1'b0;
      @(negedge clk_i);
      chk("stray_ack_busy", {31'd0, busy_o}, 32'd0);
      chk("stray_ack_done", {31'd0, done_o}, 32'd0);

      for (int i = 0; i < 60; i++) begin
         r  = int'($urandom_range(0, 9));
         op = (r < 4) ? 7'h03 : (r < 8) ? 7'h23 : (r == 8) ? 7'h33 : 7'h13;
         run_op(op, 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
                ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, TO)),
                ($urandom_range(0, 3) == 0));
      end

      repeat (4) @(negedge clk_i);
      chk("results_left", exp_q.size(), 32'd0);
      chk("reqs_left", bus_q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
